fp_normalize_pack: RTL and testbench
====================================

Name: fp_normalize_pack

Overview:
- Post-arithmetic normalizer/packer for the single-precision add/sub datapath.
- Sits after the aligned-mantissa adder/subtractor and does the reverse of pre-alignment:
  - takes the raw 25-bit mantissa sum/difference, the provisional exponent and the result sign;
  - renormalizes iteratively, one bit per cycle;
  - rounds and packs an IEEE-754 binary32 word.
- Valid/ready handshake on both sides; one operation in flight at a time.

Parameters:
- ROUND_NEAREST, 1, 1 = round-to-nearest-even on the bit dropped by the carry right-shift; 0 = truncate.
- MAX_SHIFT, 23, maximum left-normalization steps before forced underflow (bench may lower it).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset: synchronous, active-high. Asserted = 1 resets on the next clk edge, despite the name.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand.
- sign_in  in  1  result sign from the adder stage.
- exponent_temp  in  8  provisional biased exponent, the larger operand exponent.
- mant_in  in  25  raw mantissa: bit24 = carry, bit23 = hidden position, bits22:0 = fraction.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- result  out  32  packed {sign, exp[7:0], frac[22:0]}.
- overflow  out  1  result saturated to infinity.
- underflow  out  1  result flushed to signed zero.

Behaviour:
- Reset:
  - state = IDLE, in_ready = 1, out_valid = 0, result = 0, overflow = 0, underflow = 0.
  - Reset mid-operation abandons the operation; there is no partial output.
- States: IDLE, EVAL, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, register sign_in, exponent_temp and mant_in, then go to EVAL.
  - in_ready = 0 in every other state.
- EVAL (one cycle), priority order:
  - (a) mant == 0 → result {sign, 31'b0}, flags 0, go to DONE.
  - (b) exp == 255 → result {sign, 8'hFF, 23'b0}, overflow = 1, go to DONE.
  - (c) exp == 0 → flush to {sign, 31'b0}, underflow = 1, go to DONE.
  - (d) bit24 set:
    - mant >>= 1 and exp += 1, keeping the dropped bit d.
    - If ROUND_NEAREST and d = 1 and the kept LSB = 1 (tie to even; d is the only dropped bit, so d = 1 is always a tie), increment the 24-bit mantissa.
    - If the increment carries out (mant = 2^24), set mant = 0x800000 and exp += 1.
    - If the final exp ≥ 255 → infinity and overflow = 1; otherwise pack. Go to DONE.
  - (e) bit23 set → pack, go to DONE.
  - (f) otherwise → go to SHIFT.
- SHIFT (one step per cycle):
  - If exp == 1, or the step count has reached MAX_SHIFT, and bit23 is still clear → flush to signed zero, underflow = 1, go to DONE.
  - Otherwise mant <<= 1, exp −= 1, step count += 1.
  - If the new bit23 is set → pack, go to DONE.
- Pack: result = {sign, exp, mant[22:0]}.
- Exponent arithmetic uses a 9-bit internal width, so exp + 2 from 254 cannot wrap.
- DONE:
  - out_valid = 1; result and flags are held stable until out_ready.
  - On out_valid && out_ready, go to IDLE. out_valid drops next cycle and flags clear.
  - No bypass: a new operand is accepted no earlier than the cycle after the output handshake.
- Latency, counted from the accept edge to the first cycle out_valid = 1:
  - 2 cycles when no left shift is needed.
  - 2 + N cycles for N left shifts.
- Input signals are ignored outside IDLE.

Test Plan:
- 3.0 via carry: sign 0, exp 0x7F, mant 0x1800000 → result 0x40400000, flags 0, out_valid 2 cycles after accept.
- 1.5 − 1.0 with one left shift: exp 0x7F, mant 0x0400000 → result 0x3F000000, out_valid 3 cycles after accept.
- Rounding, ROUND_NEAREST = 1:
  - mant 0x1800001, exp 0x7F → 0x40400000 (tie, kept LSB even, no increment).
  - mant 0x1800003, exp 0x7F → 0x40400002.
  - mant 0x1FFFFFF, exp 0x7F → 0x40800000 (round carry renormalizes).
  - With ROUND_NEAREST = 0, mant 0x1800003 → 0x40400001.
- Zero, overflow and underflow:
  - mant 0, sign 1 → 0x80000000, flags 0.
  - exp 0xFE, mant 0x1000000 → 0x7F800000, overflow = 1.
  - exp 0x01, mant 0x0400000 → 0x00000000, underflow = 1.
- Maximum shift: exp 0x7F, mant 0x0000001 → 0x34000000 after 23 SHIFT cycles (out_valid 25 cycles after accept).
- Backpressure and reset:
  - Hold out_ready = 0 for 5 cycles: result stable, in_ready = 0, a new in_valid is ignored.
  - Assert rstn during SHIFT → next cycle IDLE, in_ready = 1, out_valid = 0, and no stale result appears afterwards.

Source files
------------

// File: rtl/fp_normalize_pack_if.sv
// Handshake bus between the add/sub mantissa stage and the normalizer/packer.
interface fp_normalize_pack_if;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [7:0]  exponent_temp;
    logic [24:0] mant_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    modport master (
        output in_valid, sign_in, exponent_temp, mant_in, out_ready,
        input  in_ready, out_valid, result, overflow, underflow
    );

    modport slave (
        input  in_valid, sign_in, exponent_temp, mant_in, out_ready,
        output in_ready, out_valid, result, overflow, underflow
    );
endinterface

// File: rtl/fp_normalize_pack.sv
// Renormalizes a raw add/sub mantissa one bit per cycle, rounds the carry case
// and packs an IEEE-754 binary32 word; one operation in flight.
module fp_normalize_pack #(
    parameter bit ROUND_NEAREST = 1'b1,
    parameter int MAX_SHIFT     = 23
) (
    input logic                clk,
    input logic                rstn,
    fp_normalize_pack_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EVAL, SHIFT, DONE} state_t;
    localparam logic [7:0] MAX_CNT = 8'(MAX_SHIFT);

    state_t      state, state_nxt;
    logic        sgn;
    logic [8:0]  exp_r;
    logic [24:0] mant_r;
    logic [7:0]  cnt;
    logic [31:0] res_r;
    logic        ovf_r, unf_r;

    logic        rnd_inc, rnd_carry, early_done, shift_stop;
    logic [22:0] rnd_frac;
    logic [8:0]  rnd_exp;
    logic [23:0] shl;
    logic [7:0]  exp_dec;

    // Carry path keeps mant[24:1]; bit0 is the only dropped bit, so a set bit0 is a tie.
    always_comb begin
        rnd_inc    = ROUND_NEAREST && mant_r[0] && mant_r[1];
        rnd_carry  = rnd_inc && (&mant_r[23:1]);
        rnd_frac   = mant_r[23:1] + {22'd0, rnd_inc};
        rnd_exp    = exp_r + (rnd_carry ? 9'd2 : 9'd1);
        shl        = {mant_r[22:0], 1'b0};
        exp_dec    = exp_r[7:0] - 8'd1;
        early_done = (mant_r == '0) || (exp_r == 9'd255) || (exp_r == 9'd0)
                     || mant_r[24] || mant_r[23];
        shift_stop = ((exp_r == 9'd1) || (cnt == MAX_CNT)) && !mant_r[23];
    end

    always_ff @(posedge clk) begin
        if (rstn) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = EVAL;
            EVAL:    state_nxt = early_done ? DONE : SHIFT;
            SHIFT:   if (shift_stop || shl[23]) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.result    = res_r;
        bus.overflow  = ovf_r;
        bus.underflow = unf_r;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            sgn    <= 1'b0;
            exp_r  <= '0;
            mant_r <= '0;
            cnt    <= '0;
            res_r  <= '0;
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    sgn    <= bus.sign_in;
                    exp_r  <= {1'b0, bus.exponent_temp};
                    mant_r <= bus.mant_in;
                    cnt    <= '0;
                end
                EVAL: begin
                    if (mant_r == '0) begin
                        res_r <= {sgn, 31'd0};
                    end else if (exp_r == 9'd255) begin
                        res_r <= {sgn, 8'hFF, 23'd0};
                        ovf_r <= 1'b1;
                    end else if (exp_r == 9'd0) begin
                        res_r <= {sgn, 31'd0};
                        unf_r <= 1'b1;
                    end else if (mant_r[24]) begin
                        if (rnd_exp >= 9'd255) begin
                            res_r <= {sgn, 8'hFF, 23'd0};
                            ovf_r <= 1'b1;
                        end else begin
                            res_r <= {sgn, rnd_exp[7:0], rnd_frac};
                        end
                    end else if (mant_r[23]) begin
                        res_r <= {sgn, exp_r[7:0], mant_r[22:0]};
                    end
                end
                SHIFT: begin
                    if (shift_stop) begin
                        res_r <= {sgn, 31'd0};
                        unf_r <= 1'b1;
                    end else begin
                        mant_r <= {1'b0, shl};
                        exp_r  <= exp_r - 9'd1;
                        cnt    <= cnt + 8'd1;
                        if (shl[23]) res_r <= {sgn, exp_dec, shl[22:0]};
                    end
                end
                DONE: if (bus.out_ready) begin
                    res_r <= '0;
                    ovf_r <= 1'b0;
                    unf_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_normalize_pack.sv
// Random and directed stimulus against an arithmetic binary32 normalize/round model;
// one DUT rounds to nearest even, a twin truncates.
module tb_fp_normalize_pack;
    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, sign_in = 1'b0, out_ready = 1'b0, hold_rdy = 1'b0;
    logic [7:0]  exponent_temp = '0;
    logic [24:0] mant_in = '0;

    fp_normalize_pack_if ia();
    fp_normalize_pack_if ib();

    assign ia.in_valid = in_valid;       assign ib.in_valid = in_valid;
    assign ia.sign_in = sign_in;         assign ib.sign_in = sign_in;
    assign ia.exponent_temp = exponent_temp; assign ib.exponent_temp = exponent_temp;
    assign ia.mant_in = mant_in;         assign ib.mant_in = mant_in;
    assign ia.out_ready = out_ready;     assign ib.out_ready = out_ready;

    fp_normalize_pack #(.ROUND_NEAREST(1'b1), .MAX_SHIFT(23)) dut_a (.clk(clk), .rstn(rstn), .bus(ia.slave));
    fp_normalize_pack #(.ROUND_NEAREST(1'b0), .MAX_SHIFT(23)) dut_b (.clk(clk), .rstn(rstn), .bus(ib.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Value-level model: halve with round-half-even on carry, else scale up by 2 until normal.
    function automatic void model(input bit s, input int e, input int m, input bit rn,
                                  output logic [31:0] r, output bit ov, output bit un, output int lat);
        int k, ee, n;
        ov = 0; un = 0; lat = 2;
        if (m == 0) r = {s, 31'd0};
        else if (e == 255) begin r = {s, 8'hFF, 23'd0}; ov = 1; end
        else if (e == 0) begin r = {s, 31'd0}; un = 1; end
        else if (m >= (1 << 24)) begin
            k = m / 2; ee = e + 1;
            if (rn && (m % 2 == 1) && (k % 2 == 1)) k++;
            if (k == (1 << 24)) begin k = 1 << 23; ee++; end
            if (ee >= 255) begin r = {s, 8'hFF, 23'd0}; ov = 1; end
            else r = {s, 8'(ee), 23'(k)};
        end else if (m >= (1 << 23)) r = {s, 8'(e), 23'(m)};
        else begin
            n = 0;
            while (m < (1 << 23)) begin m = m * 2; n++; end
            if (e - n >= 1) begin r = {s, 8'(e - n), 23'(m)}; lat = 2 + n; end
            else begin r = {s, 31'd0}; un = 1; lat = 2 + e; end
        end
    endfunction

    task automatic pin(input string nm, input bit s, input int e, input int m, input bit rn,
                       input logic [31:0] er, input bit eo, input bit eu, input int el);
        logic [31:0] r; bit o, u; int l;
        model(s, e, m, rn, r, o, u, l);
        chk({nm, "_res"}, r, er);
        chk({nm, "_flags"}, 32'({o, u}), 32'({eo, eu}));
        chk({nm, "_lat"}, 32'(l), 32'(el));
    endtask

    // Compare process: tracks the one operation in flight and checks both DUTs every cycle.
    bit          mon_en = 0, busy = 0;
    int          nclk = 0, acc = 0, la = 0, lb = 0;
    logic [31:0] ra = '0, rb = '0;
    bit          oa = 0, ua = 0, ob = 0, ub = 0, ov_exp;

    always @(negedge clk) if (mon_en) begin
        nclk++;
        ov_exp = busy && (nclk >= acc + la);
        chk("in_ready_a", 32'(ia.in_ready), 32'(!busy));
        chk("in_ready_b", 32'(ib.in_ready), 32'(!busy));
        chk("out_valid_a", 32'(ia.out_valid), 32'(ov_exp));
        chk("out_valid_b", 32'(ib.out_valid), 32'(ov_exp));
        if (ov_exp) begin
            chk("result_a", ia.result, ra);
            chk("flags_a", 32'({ia.overflow, ia.underflow}), 32'({oa, ua}));
            chk("result_b", ib.result, rb);
            chk("flags_b", 32'({ib.overflow, ib.underflow}), 32'({ob, ub}));
        end else begin
            chk("idle_flags_a", 32'({ia.overflow, ia.underflow}), 32'd0);
            chk("idle_flags_b", 32'({ib.overflow, ib.underflow}), 32'd0);
        end
        if (rstn) busy = 0;
        else if (ov_exp && out_ready) busy = 0;
        else if (!busy && in_valid) begin
            model(sign_in, int'(exponent_temp), int'(mant_in), 1'b1, ra, oa, ua, la);
            model(sign_in, int'(exponent_temp), int'(mant_in), 1'b0, rb, ob, ub, lb);
            busy = 1; acc = nclk;
        end
    end

    always @(posedge clk) begin
        #2;
        out_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m,
                        input int hold, input bit junk);
        int t;
        sign_in = s; exponent_temp = e; mant_in = m; in_valid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!ia.in_ready && t < 50);
        chk("accept_timeout", 32'(ia.in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = junk;
        sign_in = 1'($urandom); exponent_temp = 8'($urandom); mant_in = 25'($urandom);
        if (hold > 0) begin
            hold_rdy = 1'b1; t = 0;
            do begin @(negedge clk); t++; end while (!ia.out_valid && t < 50);
            repeat (hold) @(negedge clk);
            hold_rdy = 1'b0;
        end
        t = 0;
        do begin @(negedge clk); t++; end while (!(ia.out_valid && out_ready) && t < 300);
        chk("result_timeout", 32'(ia.out_valid && out_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(ia.in_ready), 32'd1);
        chk("rst_out_valid", 32'(ia.out_valid), 32'd0);
        chk("rst_result", ia.result, 32'd0);
        chk("rst_flags", 32'({ia.overflow, ia.underflow}), 32'd0);

        pin("pin_3p0",    0, 'h7F, 'h1800000, 1, 32'h40400000, 0, 0, 2);
        pin("pin_half",   0, 'h7F, 'h0400000, 1, 32'h3F000000, 0, 0, 3);
        pin("pin_tie",    0, 'h7F, 'h1800001, 1, 32'h40400000, 0, 0, 2);
        pin("pin_rnd_up", 0, 'h7F, 'h1800003, 1, 32'h40400002, 0, 0, 2);
        pin("pin_rnd_cy", 0, 'h7F, 'h1FFFFFF, 1, 32'h40800000, 0, 0, 2);
        pin("pin_trunc",  0, 'h7F, 'h1800003, 0, 32'h40400001, 0, 0, 2);
        pin("pin_negz",   1, 'h7F, 0,         1, 32'h80000000, 0, 0, 2);
        pin("pin_ovf",    0, 'hFE, 'h1000000, 1, 32'h7F800000, 1, 0, 2);
        pin("pin_unf",    0, 'h01, 'h0400000, 1, 32'h00000000, 0, 1, 3);
        pin("pin_maxsh",  0, 'h7F, 1,         1, 32'h34000000, 0, 0, 25);

        @(posedge clk); #1;
        rstn = 1'b0; mon_en = 1;

        send(0, 8'h7F, 25'h1800000, 0, 0);
        send(0, 8'h7F, 25'h0400000, 0, 0);
        send(0, 8'h7F, 25'h1800001, 0, 0);
        send(0, 8'h7F, 25'h1800003, 0, 0);
        send(0, 8'h7F, 25'h1FFFFFF, 0, 0);
        send(1, 8'h7F, 25'h0000000, 0, 0);
        send(0, 8'hFE, 25'h1000000, 0, 0);
        send(0, 8'h01, 25'h0400000, 0, 0);
        send(0, 8'h7F, 25'h0000001, 0, 0);
        send(1, 8'hFF, 25'h0800000, 0, 0);
        send(0, 8'h7F, 25'h1800003, 5, 1);

        // abandon a long normalization mid-SHIFT
        sign_in = 0; exponent_temp = 8'h7F; mant_in = 25'h1; in_valid = 1'b1;
        @(negedge clk);
        chk("rst_test_accept", 32'(ia.in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1 rstn = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 32'(ia.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(ia.out_valid), 32'd0);
        repeat (30) @(posedge clk);
        #1;

        for (int i = 0; i < 200; i++) begin
            int cls;
            logic [7:0] e;
            logic [24:0] m;
            cls = int'($urandom_range(0, 5));
            e = 8'($urandom_range(1, 254));
            case (cls)
                0: m = {1'b1, 24'($urandom)};
                1: m = {2'b01, 23'($urandom)};
                2: m = 25'($urandom_range(1, 32'h7FFFFF)) >> $urandom_range(0, 22);
                3: begin
                    m = 25'($urandom);
                    case ($urandom_range(0, 5))
                        0: e = 8'h00;
                        1: e = 8'h01;
                        2: e = 8'h02;
                        3: e = 8'h03;
                        4: e = 8'hFE;
                        default: e = 8'hFF;
                    endcase
                end
                4: m = '0;
                default: begin
                    m = 25'h1FFFFFF ^ 25'($urandom_range(0, 3));
                    e = 8'($urandom_range(250, 254));
                end
            endcase
            send(1'($urandom), e, m, ($urandom_range(0, 9) == 0) ? 3 : 0, 1'($urandom));
        end

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
